// File: rtl/shift_rows_pkg.sv
// Shared constants, types and compile-time index helpers for the ShiftRows unit.
package shift_rows_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        SR_FWD = 1'b0,
        SR_INV = 1'b1
    } mode_e;

    function automatic int nrows(input int reg_size);
        return reg_size / BYTE_W;
    endfunction

    // Rows deeper than the column count wrap their shift amount modulo NC.
    function automatic int src_col(input int c, input int r, input logic inv, input int nc);
        int k;
        k = r % nc;
        if (inv)
            return (c + nc - k) % nc;
        else
            return (c + k) % nc;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; pure wiring plus a 2:1 mux per byte.
module shift_rows_perm
    import shift_rows_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4
) (
    input  logic [vecSize-1:0][regSize-1:0] i_vect,
    input  logic                            i_inv,
    output logic [vecSize-1:0][regSize-1:0] o_vect
);

    localparam int NR = nrows(regSize);

    mode_e w_mode;
    assign w_mode = mode_e'(i_inv);

    for (genvar c = 0; c < vecSize; c++) begin : g_col
        for (genvar r = 0; r < NR; r++) begin : g_row
            localparam int HI = regSize - 1 - BYTE_W * r;
            localparam int SF = src_col(c, r, 1'b0, vecSize);
            localparam int SI = src_col(c, r, 1'b1, vecSize);
            assign o_vect[c][HI -: BYTE_W] = (w_mode == SR_INV) ? i_vect[SI][HI -: BYTE_W]
                                                                : i_vect[SF][HI -: BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Two-stage valid/ready pipelined ShiftRows unit with flush and a completed-transaction counter.
module shift_rows_pipe
    import shift_rows_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4,
    parameter int CNT_W   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic                            i_in_inv,
    input  logic [vecSize-1:0][regSize-1:0] i_vect_in,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [vecSize-1:0][regSize-1:0] o_vect_out,
    output logic                            o_out_inv,
    output logic [CNT_W-1:0]                o_done_count
);

    logic                            r_s1_valid;
    logic                            r_s1_inv;
    logic [vecSize-1:0][regSize-1:0] r_s1_data;
    logic                            r_out_valid;
    logic                            r_out_inv;
    logic [vecSize-1:0][regSize-1:0] r_out_data;
    logic [CNT_W-1:0]                r_done_count;

    logic                            w_s1_load;
    logic                            w_s2_load;
    logic [vecSize-1:0][regSize-1:0] w_perm;

    // in_ready depends only on state, out_ready and flush, never on in_valid.
    assign w_s2_load  = r_s1_valid && (!r_out_valid || i_out_ready);
    assign o_in_ready = i_rst_n && !i_flush && (!r_s1_valid || w_s2_load);
    assign w_s1_load  = i_in_valid && o_in_ready;

    shift_rows_perm #(
        .regSize(regSize),
        .vecSize(vecSize)
    ) u_perm (
        .i_vect(r_s1_data),
        .i_inv (r_s1_inv),
        .o_vect(w_perm)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done_count <= '0;
        end else if (i_flush) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_s1_load)
                r_s1_valid <= 1'b1;
            else if (w_s2_load)
                r_s1_valid <= 1'b0;

            if (w_s2_load)
                r_out_valid <= 1'b1;
            else if (i_out_ready)
                r_out_valid <= 1'b0;

            if (r_out_valid && i_out_ready)
                r_done_count <= r_done_count + 1'b1;
        end
    end

    // Data registers keep their contents across a flush; only the valids are cleared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_data  <= '0;
            r_s1_inv   <= 1'b0;
            r_out_data <= '0;
            r_out_inv  <= 1'b0;
        end else if (!i_flush) begin
            if (w_s1_load) begin
                r_s1_data <= i_vect_in;
                r_s1_inv  <= i_in_inv;
            end
            if (w_s2_load) begin
                r_out_data <= w_perm;
                r_out_inv  <= r_s1_inv;
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_vect_out   = r_out_data;
    assign o_out_inv    = r_out_inv;
    assign o_done_count = r_done_count;

endmodule
